// File: rtl/param_data_memory_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : param_data_memory_if                                          |
// | Brief    : req/ack request bus and response bus of the data memory.     |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface param_data_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/param_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : param_data_memory                                             |
// | Brief    : Single-port synchronous data memory with req/ack handshake,   |
// |            programmable wait states and range check. MEM_BYTE_EN enables |
// |            byte-lane writes.                                             |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module param_data_memory #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 13,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  param_data_memory_if.slave   bus
);
  localparam int c_be_w  = DATA_W / 8;
  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_be_w-1:0]   r_be;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_idle;
  logic                w_accept;
  logic                w_enter_resp;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [c_be_w-1:0]   w_acc_be;
  logic                w_in_range;
  logic [c_idx_w-1:0]  w_idx;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && bus.req_valid;

  // With zero wait states the array is accessed on the accept edge itself,
  // before the holding registers are loaded, so use the live request there.
  assign w_acc_wr    = w_idle ? bus.req_wr    : r_wr;
  assign w_acc_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_acc_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_acc_be    = w_idle ? bus.req_be    : r_be;
  assign w_in_range  = 32'(w_acc_addr) < 32'(DEPTH);
  assign w_idx       = w_acc_addr[c_idx_w-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr    <= bus.req_wr;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
      if (w_enter_resp) begin
        r_err <= !w_in_range;
        if (!w_acc_wr) begin
          r_rdata <= w_in_range ? r_mem[w_idx] : '0;
        end
      end
    end
  end

  // Array has no reset; rst_n gating keeps a request seen during reset from committing.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_acc_wr && w_in_range) begin
`ifdef MEM_BYTE_EN
      for (int i = 0; i < c_be_w; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
`else
      r_mem[w_idx] <= w_acc_wdata;
`endif
    end
  end

`ifndef MEM_BYTE_EN
  logic w_unused_be;
  assign w_unused_be = ^w_acc_be;
`endif

  assign bus.req_ready = w_idle;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_param_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_param_data_memory                                          |
// | Brief    : Directed bench for param_data_memory, zero- and three-wait     |
// |            instances, honouring MEM_BYTE_EN.                             |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_param_data_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_data_memory_if #(.DATA_W(16), .ADDR_W(13)) if0 ();
  param_data_memory_if #(.DATA_W(16), .ADDR_W(13)) if3 ();

  param_data_memory #(.DATA_W(16), .ADDR_W(13), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  param_data_memory #(.DATA_W(16), .ADDR_W(13), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave)
  );

  typedef struct {
    string       tag;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model [2][1024];
  logic [15:0] last  [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic wr,
                         input logic [12:0] a, input logic [15:0] d, input logic [1:0] be);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_wr = wr; if0.req_addr = a; if0.req_wdata = d; if0.req_be = be;
    end else begin
      if3.req_valid = v; if3.req_wr = wr; if3.req_addr = a; if3.req_wdata = d; if3.req_be = be;
    end
  endtask

  // {req_ready, rsp_valid, rsp_err, rsp_rdata}
  function automatic logic [18:0] mon(input int sel);
    if (sel == 0) return {if0.req_ready, if0.rsp_valid, if0.rsp_err, if0.rsp_rdata};
    return {if3.req_ready, if3.rsp_valid, if3.rsp_err, if3.rsp_rdata};
  endfunction

  task automatic txn(input int sel, input logic wr, input logic [12:0] a,
                     input logic [15:0] d, input logic [1:0] be, input logic hold,
                     input string tag);
    exp_t        e;
    logic [18:0] m;
    int          lat = 0;
    int          low = 0;
    @(negedge clk);
    e.tag   = tag;
    e.err   = (a >= 13'd1024);
    e.rdata = wr ? last[sel] : ((a >= 13'd1024) ? 16'h0000 : model[sel][a]);
    sb.push_back(e);
    if (wr && a < 13'd1024) begin
`ifdef MEM_BYTE_EN
      for (int b = 0; b < 2; b++) if (be[b]) model[sel][a][8*b +: 8] = d[8*b +: 8];
`else
      model[sel][a] = d;
`endif
    end
    m = mon(sel);
    chk({tag, " ready"}, 32'(m[18]), 32'd1);
    set_req(sel, 1'b1, wr, a, d, be);
    @(posedge clk);
    #1 if (!hold) set_req(sel, 1'b0, wr, a, d, be);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m = mon(sel);
      lat++;
      if (!m[18]) low++;
      if (m[17]) break;
    end
    chk({tag, " latency"}, 32'(lat), (sel == 0) ? 32'd1 : 32'd4);
    chk({tag, " ready_low"}, 32'(low), 32'(lat));
    e = sb.pop_front();
    chk({e.tag, " err"}, 32'(m[16]), 32'(e.err));
    chk({e.tag, " rdata"}, 32'(m[15:0]), 32'(e.rdata));
    if (!wr) last[sel] = e.rdata;
  endtask

  initial begin
    logic [18:0] m;
    set_req(0, 1'b0, 1'b0, 13'd0, 16'h0, 2'b00);
    set_req(1, 1'b0, 1'b0, 13'd0, 16'h0, 2'b00);
    last[0] = 16'h0;
    last[1] = 16'h0;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      m = mon(s);
      chk("reset ready", 32'(m[18]), 32'd1);
      chk("reset valid", 32'(m[17]), 32'd0);
      chk("reset err",   32'(m[16]), 32'd0);
      chk("reset rdata", 32'(m[15:0]), 32'h0);
    end
    rst_n = 1'b1;

    txn(0, 1'b1, 13'd0,    16'h0005, 2'b11, 1'b0, "w0 wr@0");
    txn(0, 1'b0, 13'd0,    16'h0000, 2'b11, 1'b0, "w0 rd@0");
    txn(0, 1'b1, 13'd1023, 16'h7777, 2'b11, 1'b0, "w0 wr@1023");
    txn(0, 1'b1, 13'd1024, 16'hBEEF, 2'b11, 1'b0, "oor wr@1024");
    txn(0, 1'b0, 13'd1024, 16'h0000, 2'b11, 1'b0, "oor rd@1024");
    txn(0, 1'b0, 13'd0,    16'h0000, 2'b11, 1'b0, "oor rd@0");
    txn(0, 1'b0, 13'd1023, 16'h0000, 2'b11, 1'b0, "oor rd@1023");
    @(negedge clk);
    m = mon(0);
    chk("hold valid", 32'(m[17]), 32'd0);
    chk("hold rdata", 32'(m[15:0]), 32'h7777);

    txn(1, 1'b1, 13'd1, 16'h0001, 2'b11, 1'b0, "w3 wr@1");
    txn(1, 1'b0, 13'd1, 16'h0000, 2'b11, 1'b1, "w3 rd@1 held");
    txn(1, 1'b0, 13'd1, 16'h0000, 2'b11, 1'b0, "w3 rd@1 b2b");

    txn(1, 1'b1, 13'd2, 16'h0000, 2'b11, 1'b0, "abort pre wr@2");
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 13'd2, 16'h1234, 2'b11);
    @(posedge clk);
    #1 set_req(1, 1'b0, 1'b0, 13'd0, 16'h0, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1 m = mon(1);
    chk("abort ready", 32'(m[18]), 32'd1);
    chk("abort valid", 32'(m[17]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last[0] = 16'h0;
    last[1] = 16'h0;
    txn(1, 1'b0, 13'd2, 16'h0000, 2'b11, 1'b0, "abort rd@2");

    txn(0, 1'b1, 13'd3, 16'h0006, 2'b11, 1'b0, "be wr@3 full");
    txn(0, 1'b1, 13'd3, 16'hAB00, 2'b10, 1'b0, "be wr@3 hi");
    txn(0, 1'b0, 13'd3, 16'h0000, 2'b11, 1'b0, "be rd@3");
`ifdef MEM_BYTE_EN
    chk("be model", 32'(model[0][3]), 32'h0000AB06);
`else
    chk("be model", 32'(model[0][3]), 32'h0000AB00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
